// File: rtl/shift_sched_pkg.sv
// Shared defaults, FSM state type and direction encodings for the shift scheduler.
package shift_sched_pkg;

  localparam int unsigned WIDTH_DEF = 32;
  localparam int unsigned AMT_W_DEF = 5;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

endpackage

// File: rtl/shift_core.sv
// Iterative shifter: loads an operand and direction, then shifts one bit per enabled cycle.
module shift_core
  import shift_sched_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic             i_en,
  input  logic             i_dir,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;
  logic             r_dir;

  // Operand register: load wins over shift; logical shift with zero fill.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_q   <= '0;
      r_dir <= DIR_LEFT;
    end else if (i_load) begin
      r_q   <= i_data;
      r_dir <= i_dir;
    end else if (i_en) begin
      if (r_dir == DIR_RIGHT) begin
        r_q <= {1'b0, r_q[WIDTH-1:1]};
      end else begin
        r_q <= {r_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/shift_sched.sv
// Two-requester round-robin front end feeding an iterative shifter with a valid/ready response.
module shift_sched
  import shift_sched_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned AMT_W = AMT_W_DEF
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_data,
  input  logic             req0_dir,
  input  logic [AMT_W-1:0] req0_amt,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_data,
  input  logic             req1_dir,
  input  logic [AMT_W-1:0] req1_amt,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id,
  output logic             busy
);

  state_e           r_state;
  state_e           w_state_next;
  logic             r_last;       // requester served most recently; 1 after reset so req0 wins
  logic [AMT_W-1:0] r_cnt;
  logic             r_id;

  logic             w_grant;
  logic             w_open;
  logic             w_accept;
  logic             w_shift_en;
  logic [WIDTH-1:0] w_sel_data;
  logic             w_sel_dir;
  logic [AMT_W-1:0] w_sel_amt;
  logic [WIDTH-1:0] w_core_q;

  // Arbiter: contention goes to the requester not served last; a lone valid wins outright.
  always_comb begin
    w_grant    = (req0_valid && req1_valid) ? ~r_last : req1_valid;
    w_open     = (r_state == StIdle) && !clr;
    req0_ready = w_open && req0_valid && !w_grant;
    req1_ready = w_open && req1_valid && w_grant;
    w_accept   = req0_ready || req1_ready;
    w_sel_data = w_grant ? req1_data : req0_data;
    w_sel_dir  = w_grant ? req1_dir  : req0_dir;
    w_sel_amt  = w_grant ? req1_amt  : req0_amt;
  end

  // Next-state logic and shift enable.
  always_comb begin
    w_state_next = r_state;
    w_shift_en   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_state_next = (w_sel_amt != '0) ? StShift : StDone;
        end
      end
      StShift: begin
        w_shift_en = 1'b1;
        if (r_cnt == AMT_W'(1)) begin
          w_state_next = StDone;
        end
      end
      StDone: begin
        if (rsp_ready) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Round-robin pointer and response owner, both captured only on accept.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_last <= 1'b1;
      r_id   <= 1'b0;
    end else if (w_accept) begin
      r_last <= w_grant;
      r_id   <= w_grant;
    end
  end

  // Remaining-shift counter.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= w_sel_amt;
    end else if (w_shift_en) begin
      r_cnt <= r_cnt - AMT_W'(1);
    end
  end

  shift_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .i_clk  (clk),
    .i_clr  (clr),
    .i_load (w_accept),
    .i_en   (w_shift_en),
    .i_dir  (w_sel_dir),
    .i_data (w_sel_data),
    .o_q    (w_core_q)
  );

  assign rsp_valid = (r_state == StDone);
  assign busy      = (r_state != StIdle);
  assign rsp_data  = w_core_q;
  assign rsp_id    = r_id;

endmodule

// File: tb/tb_shift_sched.sv
// Self-checking bench: directed scenarios plus randomized commands against a transaction model.
module tb_shift_sched;

  logic        clk = 1'b0;
  logic        clr;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_data, req1_data;
  logic        req0_dir, req1_dir;
  logic [4:0]  req0_amt, req1_amt;
  logic        rsp_valid, rsp_ready, rsp_id, busy;
  logic [31:0] rsp_data;

  int n_checks = 0;
  int n_errors = 0;
  logic m_last;  // model: requester served most recently

  shift_sched #(
    .WIDTH (32),
    .AMT_W (5)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_data  (req0_data),
    .req0_dir   (req0_dir),
    .req0_amt   (req0_amt),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_data  (req1_data),
    .req1_dir   (req1_dir),
    .req1_amt   (req1_amt),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic dir, input int amt);
    return dir ? (d >> amt) : (d << amt);
  endfunction

  // Random garbage on the request side while the block must not accept anything.
  task automatic junk(input logic vld);
    req0_valid = vld | 1'($urandom_range(0, 1));
    req1_valid = vld | 1'($urandom_range(0, 1));
    req0_data  = $urandom;
    req1_data  = $urandom;
    req0_dir   = 1'($urandom_range(0, 1));
    req1_dir   = 1'($urandom_range(0, 1));
    req0_amt   = 5'($urandom_range(0, 31));
    req1_amt   = 5'($urandom_range(0, 31));
  endtask

  // One full command: present, accept, wait for result, hold off for 'hold' cycles, hand off.
  task automatic run_cmd(input logic v0, input logic v1,
                         input logic [31:0] d0, input logic [31:0] d1,
                         input logic dr0, input logic dr1,
                         input logic [4:0] a0, input logic [4:0] a1, input int hold);
    logic        g;
    int          k;
    int          ea;
    logic [31:0] ed;
    @(negedge clk);
    req0_valid = v0; req0_data = d0; req0_dir = dr0; req0_amt = a0;
    req1_valid = v1; req1_data = d1; req1_dir = dr1; req1_amt = a1;
    rsp_ready  = 1'b0;
    #1;
    g  = (v0 && v1) ? ~m_last : v1;
    ea = g ? int'(a1) : int'(a0);
    ed = g ? ref_shift(d1, dr1, ea) : ref_shift(d0, dr0, ea);
    check_eq("grant_rdy0", 32'(req0_ready), 32'(v0 && !g));
    check_eq("grant_rdy1", 32'(req1_ready), 32'(v1 && g));
    @(posedge clk);
    m_last = g;
    #1;
    junk(1'b0);
    k = 0;
    @(negedge clk);
    while (!rsp_valid && k < 40) begin
      check_eq("shift_rdys", 32'({req0_ready, req1_ready}), 32'd0);
      check_eq("shift_busy", 32'(busy), 32'd1);
      junk(1'b0);
      @(negedge clk);
      k++;
    end
    check_eq("latency", 32'(k), 32'(ea));
    check_eq("rsp_data", rsp_data, ed);
    check_eq("rsp_id", 32'(rsp_id), 32'(g));
    repeat (hold) begin
      junk(1'b1);
      @(negedge clk);
      check_eq("hold_valid", 32'(rsp_valid), 32'd1);
      check_eq("hold_data", rsp_data, ed);
      check_eq("hold_id", 32'(rsp_id), 32'(g));
      check_eq("hold_rdys", 32'({req0_ready, req1_ready}), 32'd0);
    end
    // Handshake cycle: valids high, yet nothing may be accepted alongside the response.
    rsp_ready = 1'b1;
    junk(1'b1);
    #1;
    check_eq("hs_valid", 32'(rsp_valid), 32'd1);
    check_eq("hs_rdys", 32'({req0_ready, req1_ready}), 32'd0);
    @(posedge clk);
    #1;
    rsp_ready  = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    check_eq("post_valid", 32'(rsp_valid), 32'd0);
    check_eq("post_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    clr = 1'b1; rsp_ready = 1'b0;
    junk(1'b1);
    m_last = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("clr_rdys", 32'({req0_ready, req1_ready}), 32'd0);
    clr = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    check_eq("rst_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_data", rsp_data, 32'd0);
    check_eq("rst_id", 32'(rsp_id), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);

    // Contention from reset: req0 first, then alternation.
    run_cmd(1, 1, 32'h1111_0001, 32'h2222_0002, 0, 1, 1, 1, 0);
    check_eq("rr_first", 32'(rsp_id), 32'd0);
    run_cmd(1, 1, 32'h1111_0001, 32'h2222_0002, 0, 1, 1, 1, 0);
    check_eq("rr_second", 32'(rsp_id), 32'd1);
    run_cmd(1, 1, 32'h8000_0001, 32'h8000_0001, 1, 0, 1, 1, 0);
    check_eq("rr_third", 32'(rsp_id), 32'd0);

    run_cmd(1, 0, 32'h7105c1a6, 32'h0, 0, 0, 12, 0, 0);
    check_eq("dir_left_12", rsp_data, 32'h5c1a6000);
    run_cmd(0, 1, 32'h0, 32'h7105c1a6, 0, 1, 0, 5, 0);
    check_eq("dir_right_5", rsp_data, 32'h03882e0d);
    run_cmd(1, 0, 32'hdeadbeef, 32'h0, 1, 0, 0, 0, 0);
    check_eq("amt_zero", rsp_data, 32'hdeadbeef);
    run_cmd(0, 1, 32'h0, 32'hcafe_f00d, 0, 0, 0, 3, 3);

    // Reset in the middle of a 12-bit shift.
    @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b0;
    req0_data = 32'h7105c1a6; req0_dir = 1'b0; req0_amt = 5'd12;
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_eq("pre_clr_busy", 32'(busy), 32'd1);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    m_last = 1'b1;
    @(negedge clk);
    check_eq("clr_valid", 32'(rsp_valid), 32'd0);
    check_eq("clr_busy", 32'(busy), 32'd0);
    check_eq("clr_data", rsp_data, 32'd0);
    run_cmd(1, 1, 32'h0000_00ff, 32'hffff_0000, 0, 1, 4, 4, 1);
    check_eq("after_clr_id", 32'(rsp_id), 32'd0);

    for (int i = 0; i < 40; i++) begin
      logic v0, v1;
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      if (!v0 && !v1) v0 = 1'b1;
      run_cmd(v0, v1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
